encout_seq_ctrl: RTL and testbench

//   Sequencer for the encoder-output channel. Takes the ENCOUT register-block settings:
//     POL, ENCE, POSMAX, PDCNT, signed EDGECNT, initial POSCNT.

---
 rtl/encout_if.sv | 33 +++
 rtl/encout_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_encout_seq_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/encout_if.sv
// Encoder-output channel bundle: ENCOUT register settings in,
// quadrature pins and status out.
interface encout_if #(
    parameter int CNT_W = 16
);
    logic             i_ence;
    logic             i_pol;
    logic [CNT_W-1:0] i_posmax;
    logic [CNT_W-1:0] i_pdcnt;
    logic [CNT_W-1:0] i_edgecnt;
    logic [CNT_W-1:0] i_poscnt_int;
    logic             i_cmd_load;
    logic             o_enc_a;
    logic             o_enc_b;
    logic [CNT_W-1:0] o_poscnt_cur;
    logic             o_busy;
    logic             o_done;
    logic             o_ovr;

    modport master (
        output i_ence, i_pol, i_posmax, i_pdcnt,
        output i_edgecnt, i_poscnt_int, i_cmd_load,
        input  o_enc_a, o_enc_b, o_poscnt_cur,
        input  o_busy, o_done, o_ovr
    );

    modport slave (
        input  i_ence, i_pol, i_posmax, i_pdcnt,
        input  i_edgecnt, i_poscnt_int, i_cmd_load,
        output o_enc_a, o_enc_b, o_poscnt_cur,
        output o_busy, o_done, o_ovr
    );
endinterface

// File: rtl/encout_seq_ctrl.sv
// Encoder-output sequencer: emits a signed burst of quadrature edges
// at a fixed pitch and tracks the wrapped position.
module encout_seq_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic i_pclk,
    input  logic i_prst,
    encout_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ZERO = '0;

    state_t           r_state;
    state_t           w_next;
    logic             r_ence_d;
    logic             r_dir;
    logic [1:0]       r_q;
    logic [CNT_W-1:0] r_pos;
    logic [CNT_W-1:0] r_tmr;
    logic [CNT_W-1:0] r_rem;
    logic [CNT_W-1:0] r_pd;
    logic             r_a;
    logic             r_b;

    logic             w_rise;
    logic             w_start;
    logic             w_edge;
    logic [CNT_W-1:0] w_abs;
    logic [1:0]       w_qn;
    logic [CNT_W-1:0] w_posn;

    assign w_rise = bus.i_ence & ~r_ence_d;
    assign w_abs  = bus.i_edgecnt[CNT_W-1] ? (~bus.i_edgecnt + ONE)
                                           : bus.i_edgecnt;

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_edge  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.i_cmd_load) begin
                    w_start = 1'b1;
                    if (w_abs == ZERO || bus.i_pdcnt == ZERO)
                        w_next = S_DONE;
                    else
                        w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (r_tmr == ZERO) begin
                    w_edge = 1'b1;
                    if (r_rem == ONE)
                        w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        // Disable wins over everything: abort silently to IDLE
        if (!bus.i_ence) begin
            w_next  = S_IDLE;
            w_start = 1'b0;
            w_edge  = 1'b0;
        end
    end

    always_comb begin
        w_qn   = r_q;
        w_posn = r_pos;
        if (!r_dir) begin
            unique case (r_q)
                2'b00:   w_qn = 2'b10;
                2'b10:   w_qn = 2'b11;
                2'b11:   w_qn = 2'b01;
                default: w_qn = 2'b00;
            endcase
            w_posn = (r_pos == bus.i_posmax) ? ZERO : r_pos + ONE;
        end else begin
            unique case (r_q)
                2'b00:   w_qn = 2'b01;
                2'b01:   w_qn = 2'b11;
                2'b11:   w_qn = 2'b10;
                default: w_qn = 2'b00;
            endcase
            w_posn = (r_pos == ZERO) ? bus.i_posmax : r_pos - ONE;
        end
    end

    always_ff @(posedge i_pclk) begin
        if (i_prst) begin
            r_state  <= S_IDLE;
            r_ence_d <= 1'b0;
            r_dir    <= 1'b0;
            r_q      <= 2'b00;
            r_pos    <= ZERO;
            r_tmr    <= ZERO;
            r_rem    <= ZERO;
            r_pd     <= ZERO;
            r_a      <= 1'b0;
            r_b      <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_ence_d <= bus.i_ence;
            r_a      <= r_q[1] ^ bus.i_pol;
            r_b      <= r_q[0] ^ bus.i_pol;
            if (w_rise) begin
                r_pos <= bus.i_poscnt_int;
                r_q   <= 2'b00;
            end
            if (!bus.i_ence) begin
                r_tmr <= ZERO;
                r_rem <= ZERO;
            end else if (w_start) begin
                r_dir <= bus.i_edgecnt[CNT_W-1];
                r_rem <= w_abs;
                r_pd  <= bus.i_pdcnt;
                r_tmr <= bus.i_pdcnt - ONE;
            end else if (w_edge) begin
                r_q   <= w_qn;
                r_pos <= w_posn;
                r_tmr <= r_pd - ONE;
                r_rem <= r_rem - ONE;
            end else if (r_state == S_RUN) begin
                r_tmr <= r_tmr - ONE;
            end
        end
    end

    assign bus.o_enc_a      = r_a;
    assign bus.o_enc_b      = r_b;
    assign bus.o_poscnt_cur = r_pos;
    assign bus.o_busy       = (r_state == S_RUN);
    assign bus.o_done       = (r_state == S_DONE);
    assign bus.o_ovr        = bus.i_cmd_load & ~i_prst
                            & ((r_state != S_IDLE) | ~bus.i_ence);
endmodule

// File: tb/tb_encout_seq_ctrl.sv
// Directed bench for encout_seq_ctrl: bursts, wrap, degenerate,
// abort, overrun and polarity cases.
module tb_encout_seq_ctrl;
    logic i_pclk = 1'b0;
    logic i_prst;
    int   n_pass = 0;
    int   n_chk  = 0;
    int   n;
    logic [1:0] ab_exp [4];

    encout_if #(.CNT_W(16)) bus ();

    encout_seq_ctrl #(.CNT_W(16)) dut (
        .i_pclk (i_pclk),
        .i_prst (i_prst),
        .bus    (bus.slave)
    );

    always #5 i_pclk = ~i_pclk;

    task automatic tick();
        @(posedge i_pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ab();
        return 32'({bus.o_enc_a, bus.o_enc_b});
    endfunction

    function automatic logic [31:0] pos();
        return 32'(bus.o_poscnt_cur);
    endfunction

    initial begin
        ab_exp[0] = 2'b10;
        ab_exp[1] = 2'b11;
        ab_exp[2] = 2'b01;
        ab_exp[3] = 2'b00;

        // Reset with inverted polarity
        i_prst           = 1'b1;
        bus.i_pol        = 1'b1;
        bus.i_ence       = 1'b0;
        bus.i_posmax     = '0;
        bus.i_pdcnt      = '0;
        bus.i_edgecnt    = '0;
        bus.i_poscnt_int = '0;
        bus.i_cmd_load   = 1'b0;
        tick();
        chk("rst_ab", ab(), 32'd0);
        chk("rst_pos", pos(), 32'd0);
        chk("rst_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_done", 32'(bus.o_done), 32'd0);
        tick();
        chk("rst_ab2", ab(), 32'd0);
        i_prst = 1'b0;
        tick();
        chk("idle_ab_inv", ab(), 32'd3);

        // Forward burst
        bus.i_pol        = 1'b0;
        bus.i_ence       = 1'b1;
        bus.i_poscnt_int = 16'd5;
        bus.i_posmax     = 16'd100;
        bus.i_pdcnt      = 16'd3;
        bus.i_edgecnt    = 16'd4;
        bus.i_cmd_load   = 1'b1;
        tick();
        bus.i_cmd_load = 1'b0;
        chk("fw_busy", 32'(bus.o_busy), 32'd1);
        chk("fw_pos0", pos(), 32'd5);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k >= 2) chk("fw_ab_lag", ab(), 32'(ab_exp[k-2]));
            tick();
            tick();
            chk("fw_pos", pos(), 32'(5 + k));
            chk("fw_done", 32'(bus.o_done), 32'(k == 4));
        end
        tick();
        chk("fw_ab_last", ab(), 32'(ab_exp[3]));
        chk("fw_done_off", 32'(bus.o_done), 32'd0);
        chk("fw_idle", 32'(bus.o_busy), 32'd0);

        // Reverse burst with wrap through 0
        bus.i_ence = 1'b0;
        tick();
        bus.i_ence       = 1'b1;
        bus.i_poscnt_int = 16'd1;
        bus.i_posmax     = 16'd9;
        bus.i_pdcnt      = 16'd1;
        bus.i_edgecnt    = 16'hFFFD;
        bus.i_cmd_load   = 1'b1;
        tick();
        bus.i_cmd_load = 1'b0;
        chk("rv_pos_init", pos(), 32'd1);
        tick();
        chk("rv_pos1", pos(), 32'd0);
        tick();
        chk("rv_pos2", pos(), 32'd9);
        chk("rv_ab1", ab(), 32'd1);
        tick();
        chk("rv_pos3", pos(), 32'd8);
        chk("rv_ab2", ab(), 32'd3);
        chk("rv_done", 32'(bus.o_done), 32'd1);
        tick();
        chk("rv_ab3", ab(), 32'd2);

        // Zero-length bursts
        bus.i_pdcnt    = 16'd5;
        bus.i_edgecnt  = 16'd0;
        bus.i_cmd_load = 1'b1;
        tick();
        bus.i_cmd_load = 1'b0;
        chk("z0_done", 32'(bus.o_done), 32'd1);
        chk("z0_busy", 32'(bus.o_busy), 32'd0);
        tick();
        chk("z0_done_off", 32'(bus.o_done), 32'd0);
        chk("z0_pos", pos(), 32'd8);
        bus.i_pdcnt    = 16'd0;
        bus.i_edgecnt  = 16'd5;
        bus.i_cmd_load = 1'b1;
        tick();
        bus.i_cmd_load = 1'b0;
        chk("pd0_done", 32'(bus.o_done), 32'd1);
        tick();
        chk("pd0_pos", pos(), 32'd8);
        chk("pd0_ab", ab(), 32'd2);

        // Maximum negative count, load together with ENCE rise
        bus.i_ence = 1'b0;
        tick();
        bus.i_ence       = 1'b1;
        bus.i_poscnt_int = 16'd50;
        bus.i_posmax     = 16'd100;
        bus.i_pdcnt      = 16'd1;
        bus.i_edgecnt    = 16'h8000;
        bus.i_cmd_load   = 1'b1;
        tick();
        bus.i_cmd_load = 1'b0;
        chk("max_busy", 32'(bus.o_busy), 32'd1);
        chk("max_pos0", pos(), 32'd50);
        n = 0;
        while (!bus.o_done && n < 40000) begin
            tick();
            n++;
        end
        chk("max_cycles", 32'(n), 32'd32768);
        chk("max_pos", pos(), 32'd6);
        tick();
        chk("max_ab", ab(), 32'd0);

        // Abort by dropping ENCE after two edges
        bus.i_ence = 1'b0;
        tick();
        bus.i_ence       = 1'b1;
        bus.i_poscnt_int = 16'd5;
        bus.i_pdcnt      = 16'd3;
        bus.i_edgecnt    = 16'd4;
        bus.i_cmd_load   = 1'b1;
        tick();
        bus.i_cmd_load = 1'b0;
        repeat (6) tick();
        chk("ab_pos2", pos(), 32'd7);
        bus.i_ence = 1'b0;
        tick();
        chk("ab_busy", 32'(bus.o_busy), 32'd0);
        chk("ab_done", 32'(bus.o_done), 32'd0);
        bus.i_cmd_load = 1'b1;
        #1;
        chk("ovr_dis", 32'(bus.o_ovr), 32'd1);
        tick();
        bus.i_cmd_load = 1'b0;
        chk("ab_done2", 32'(bus.o_done), 32'd0);
        chk("ab_busy2", 32'(bus.o_busy), 32'd0);
        chk("ab_hold", pos(), 32'd7);
        bus.i_ence = 1'b1;
        tick();
        chk("ab_reload", pos(), 32'd5);

        // Overrun during RUN, then polarity flip mid-burst
        bus.i_cmd_load = 1'b1;
        tick();
        bus.i_cmd_load = 1'b0;
        chk("ov_busy", 32'(bus.o_busy), 32'd1);
        tick();
        bus.i_cmd_load = 1'b1;
        #1;
        chk("ov_pulse", 32'(bus.o_ovr), 32'd1);
        tick();
        bus.i_cmd_load = 1'b0;
        #1;
        chk("ov_clear", 32'(bus.o_ovr), 32'd0);
        tick();
        chk("ov_pos1", pos(), 32'd6);
        chk("ov_ab0", ab(), 32'd0);
        bus.i_pol = 1'b1;
        tick();
        chk("pol_ab1", ab(), 32'd1);
        tick();
        tick();
        chk("pol_pos2", pos(), 32'd7);
        chk("pol_ab_hold", ab(), 32'd1);
        tick();
        chk("pol_ab2", ab(), 32'd0);
        bus.i_pol = 1'b0;
        n = 0;
        while (!bus.o_done && n < 20) begin
            tick();
            n++;
        end
        chk("ov_cycles", 32'(n), 32'd5);
        chk("ov_pos", pos(), 32'd9);

        // Reset in the middle of a burst
        tick();
        bus.i_cmd_load = 1'b1;
        tick();
        bus.i_cmd_load = 1'b0;
        tick();
        i_prst = 1'b1;
        tick();
        chk("mrst_busy", 32'(bus.o_busy), 32'd0);
        chk("mrst_pos", pos(), 32'd0);
        chk("mrst_done", 32'(bus.o_done), 32'd0);
        chk("mrst_ab", ab(), 32'd0);
        i_prst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
